mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 31 +++
 rtl/mem_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared state encoding, access-size encodings and region constants
// for the byte-serial memory controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [2:0] BYTES_BYTE = 3'd1;
    localparam logic [2:0] BYTES_HALF = 3'd2;
    localparam logic [2:0] BYTES_WORD = 3'd4;

    localparam logic [1:0] IO_SEL_DEF = 2'b11;

    // The reserved size encoding 2'b11 behaves as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return BYTES_BYTE;
            SIZE_HALF: return BYTES_HALF;
            SIZE_WORD: return BYTES_WORD;
            default:   return BYTES_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating icache fetches and LSB accesses.
// Handshake: a requester holds *_valid and its fields steady until its one-cycle *_done pulse.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [1:0]  IO_SEL     = IO_SEL_DEF
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clr_in,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full,
    input  logic                  ic_valid,
    input  logic [ADDR_WIDTH-1:0] ic_addr,
    output logic                  ic_done,
    output logic [31:0]           ic_data,
    input  logic                  lsb_valid,
    input  logic                  lsb_wr,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [1:0]            lsb_size,
    input  logic [31:0]           lsb_wdata,
    output logic                  lsb_done,
    output logic [31:0]           lsb_rdata,
    output state_e                dbg_state
);

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [2:0]            nbytes_q, nbytes_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  is_ic_q, is_ic_d;
    logic                  rr_q, rr_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [1:0]            rd_idx_q, rd_idx_d;
    logic                  hold_vld_q, hold_vld_d;
    logic [7:0]            hold_q, hold_d;
    logic [31:0]           buf_q, buf_d;
    logic                  ic_done_q, ic_done_d;
    logic                  lsb_done_q, lsb_done_d;
    logic [31:0]           ic_data_q, ic_data_d;
    logic [31:0]           lsb_rdata_q, lsb_rdata_d;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  io_block;
    logic                  grant_ic;
    logic [31:0]           rd_word;

    assign cur_addr = base_q + ADDR_WIDTH'(cnt_q);
    assign io_block = (cur_addr[17:16] == IO_SEL) && io_buffer_full;
    assign grant_ic = ic_valid && (!lsb_valid || !rr_q);

    // A byte that arrived during a stall is parked in hold_q so it is not lost.
    always_comb begin
        rd_word = buf_q;
        rd_word[{rd_idx_q, 3'b000} +: 8] = hold_vld_q ? hold_q : mem_din;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nbytes_d    = nbytes_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        is_ic_d     = is_ic_q;
        rr_d        = rr_q;
        rd_vld_d    = rd_vld_q;
        rd_idx_d    = rd_idx_q;
        hold_vld_d  = hold_vld_q;
        hold_d      = hold_q;
        buf_d       = buf_q;
        ic_done_d   = ic_done_q;
        lsb_done_d  = lsb_done_q;
        ic_data_d   = ic_data_q;
        lsb_rdata_d = lsb_rdata_q;
        mem_a       = '0;
        mem_wr      = 1'b0;
        mem_dout    = 8'h00;

        if (rdy_in) begin
            ic_done_d  = 1'b0;
            lsb_done_d = 1'b0;
            hold_vld_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (!clr_in && !ic_done_q && !lsb_done_q && (ic_valid || lsb_valid)) begin
                        is_ic_d  = grant_ic;
                        rr_d     = grant_ic;
                        cnt_d    = 3'd0;
                        rd_vld_d = 1'b0;
                        buf_d    = 32'h0;
                        if (grant_ic) begin
                            base_d   = ic_addr;
                            nbytes_d = BYTES_WORD;
                            state_d  = READ;
                        end else begin
                            base_d   = lsb_addr;
                            nbytes_d = size_bytes(lsb_size);
                            wdata_d  = lsb_wdata;
                            state_d  = lsb_wr ? WRITE : READ;
                        end
                    end
                end
                READ: begin
                    rd_vld_d = 1'b0;
                    if (cnt_q != nbytes_q) begin
                        mem_a    = cur_addr;
                        cnt_d    = cnt_q + 3'd1;
                        rd_vld_d = 1'b1;
                        rd_idx_d = cnt_q[1:0];
                    end
                    if (clr_in) begin
                        state_d  = IDLE;
                        cnt_d    = 3'd0;
                        rd_vld_d = 1'b0;
                    end else if (rd_vld_q) begin
                        buf_d = rd_word;
                        if ({1'b0, rd_idx_q} == nbytes_q - 3'd1) begin
                            state_d = IDLE;
                            cnt_d   = 3'd0;
                            if (is_ic_q) begin
                                ic_done_d = 1'b1;
                                ic_data_d = rd_word;
                            end else begin
                                lsb_done_d  = 1'b1;
                                lsb_rdata_d = rd_word;
                            end
                        end
                    end
                end
                WRITE: begin
                    mem_a    = cur_addr;
                    mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    if (!io_block) begin
                        mem_wr = 1'b1;
                        if (cnt_q == nbytes_q - 3'd1) begin
                            state_d    = IDLE;
                            cnt_d      = 3'd0;
                            lsb_done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == READ && rd_vld_q && !hold_vld_q) begin
            hold_d     = mem_din;
            hold_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            nbytes_q    <= 3'd0;
            base_q      <= '0;
            wdata_q     <= 32'h0;
            is_ic_q     <= 1'b0;
            rr_q        <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_idx_q    <= 2'd0;
            hold_vld_q  <= 1'b0;
            hold_q      <= 8'h00;
            buf_q       <= 32'h0;
            ic_done_q   <= 1'b0;
            lsb_done_q  <= 1'b0;
            ic_data_q   <= 32'h0;
            lsb_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nbytes_q    <= nbytes_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            is_ic_q     <= is_ic_d;
            rr_q        <= rr_d;
            rd_vld_q    <= rd_vld_d;
            rd_idx_q    <= rd_idx_d;
            hold_vld_q  <= hold_vld_d;
            hold_q      <= hold_d;
            buf_q       <= buf_d;
            ic_done_q   <= ic_done_d;
            lsb_done_q  <= lsb_done_d;
            ic_data_q   <= ic_data_d;
            lsb_rdata_q <= lsb_rdata_d;
        end
    end

    assign ic_done   = ic_done_q;
    assign ic_data   = ic_data_q;
    assign lsb_done  = lsb_done_q;
    assign lsb_rdata = lsb_rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: bus events are scoreboarded against an
// expected queue, completion timing and data are checked per scenario.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int AW = 32;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          clr_in;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout;
    logic [AW-1:0] mem_a;
    logic          mem_wr;
    logic          io_buffer_full;
    logic          ic_valid;
    logic [AW-1:0] ic_addr;
    logic          ic_done;
    logic [31:0]   ic_data;
    logic          lsb_valid;
    logic          lsb_wr;
    logic [AW-1:0] lsb_addr;
    logic [1:0]    lsb_size;
    logic [31:0]   lsb_wdata;
    logic          lsb_done;
    logic [31:0]   lsb_rdata;
    state_e        dbg_state;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    // {cycle[72:41], wr[40], addr[39:8], data[7:0]}
    logic [72:0] exp_q[$];
    logic [72:0] obs_ev;
    logic [72:0] exp_ev;

    mem_ctrl #(.ADDR_WIDTH(AW), .IO_SEL(2'b11)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .ic_valid(ic_valid), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
        .lsb_valid(lsb_valid), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // memory model: byte returned the cycle after its address
    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102: return 8'h10;
            32'h103: return 8'h00;
            32'h410: return 8'hDE;
            32'h411: return 8'hAD;
            32'h412: return 8'hBE;
            32'h413: return 8'hEF;
            default: return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    always @(posedge clk_in) mem_din <= rom(mem_a);

    // scoreboard: every bus cycle with an address or a write pops one expected event
    always @(negedge clk_in) begin
        if (mem_wr || mem_a != '0) begin
            obs_ev = {32'(cyc), mem_wr, mem_a, (mem_wr ? mem_dout : 8'h00)};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL bus_unexpected got cyc=%0d wr=%b a=%h d=%h, expected no bus event",
                         cyc, mem_wr, mem_a, mem_dout);
            end else begin
                exp_ev = exp_q.pop_front();
                if (obs_ev !== exp_ev) begin
                    bad++;
                    $display("FAIL bus_event got cyc=%0d wr=%b a=%h d=%h, expected cyc=%0d wr=%b a=%h d=%h",
                             obs_ev[72:41], obs_ev[40], obs_ev[39:8], obs_ev[7:0],
                             exp_ev[72:41], exp_ev[40], exp_ev[39:8], exp_ev[7:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic push_ev(input int c, input logic wr, input logic [31:0] a, input logic [7:0] d);
        exp_q.push_back({32'(c), wr, a, d});
    endtask

    task automatic wait_done(input int budget, output int dcyc, output logic was_ic,
                             output logic [31:0] data);
        dcyc   = -1;
        was_ic = 1'b0;
        data   = 32'h0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in);
            if (ic_done || lsb_done) begin
                dcyc   = cyc;
                was_ic = ic_done;
                data   = ic_done ? ic_data : lsb_rdata;
                break;
            end
        end
    endtask

    task automatic lsb_req(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] wd);
        lsb_valid = 1'b1;
        lsb_wr    = wr;
        lsb_addr  = a;
        lsb_size  = sz;
        lsb_wdata = wd;
    endtask

    task automatic test_reset();
        rst_in    = 1'b0;
        ic_valid  = 1'b1;
        ic_addr   = 32'h100;
        lsb_req(1'b1, 32'h500, 2'b10, 32'hFFFF_FFFF);
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        total++; if (mem_a !== '0)       begin bad++; $display("FAIL rst_mem_a got=%h exp=0", mem_a); end
        total++; if (mem_wr !== 1'b0)    begin bad++; $display("FAIL rst_mem_wr got=%b exp=0", mem_wr); end
        total++; if (mem_dout !== 8'h00) begin bad++; $display("FAIL rst_mem_dout got=%h exp=0", mem_dout); end
        total++; if (ic_done !== 1'b0 || lsb_done !== 1'b0) begin
            bad++; $display("FAIL rst_done got ic=%b lsb=%b exp 0/0", ic_done, lsb_done);
        end
        total++; if (ic_data !== 32'h0 || lsb_rdata !== 32'h0) begin
            bad++; $display("FAIL rst_data got ic=%h lsb=%h exp 0/0", ic_data, lsb_rdata);
        end
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, IDLE); end
        ic_valid  = 1'b0;
        lsb_valid = 1'b0;
        lsb_wr    = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b1;
    endtask

    task automatic test_icache_fetch();
        int t0, dc;
        logic wic;
        logic [31:0] d;
        @(posedge clk_in); #1;
        t0 = cyc;
        ic_valid = 1'b1;
        ic_addr  = 32'h100;
        for (int k = 0; k < 4; k++) push_ev(t0 + 1 + k, 1'b0, 32'h100 + 32'(k), 8'h00);
        wait_done(20, dc, wic, d);
        total++; if (dc !== t0 + 6) begin bad++; $display("FAIL ic_latency got=%0d exp=6", dc - t0); end
        total++; if (wic !== 1'b1 || d !== 32'h0010_0513) begin
            bad++; $display("FAIL ic_data got ic=%b data=%h exp ic=1 data=00100513", wic, d);
        end
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL ic_done_state got=%0d exp=%0d", dbg_state, IDLE); end
        @(posedge clk_in); #1;
        ic_valid = 1'b0;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ic_bus_left got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_round_robin();
        int t0, dc;
        logic wic, exp_ic;
        logic [31:0] d;
        @(posedge clk_in); #1; rst_in = 1'b0;
        @(posedge clk_in); #1; rst_in = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(posedge clk_in); #1;
            t0 = cyc;
            exp_ic   = (r != 1);
            ic_valid = 1'b1;
            ic_addr  = 32'h100;
            lsb_req(1'b0, 32'h200, 2'b00, 32'h0);
            if (exp_ic) begin
                for (int k = 0; k < 4; k++) push_ev(t0 + 1 + k, 1'b0, 32'h100 + 32'(k), 8'h00);
            end else begin
                push_ev(t0 + 1, 1'b0, 32'h200, 8'h00);
            end
            wait_done(20, dc, wic, d);
            total++; if (wic !== exp_ic) begin bad++; $display("FAIL rr_winner round=%0d got_ic=%b exp_ic=%b", r, wic, exp_ic); end
            total++; if (d !== (exp_ic ? 32'h0010_0513 : 32'h0000_005A)) begin
                bad++; $display("FAIL rr_data round=%0d got=%h", r, d);
            end
            total++; if (dc !== t0 + (exp_ic ? 6 : 3)) begin
                bad++; $display("FAIL rr_latency round=%0d got=%0d exp=%0d", r, dc - t0, exp_ic ? 6 : 3);
            end
            @(posedge clk_in); #1;
            ic_valid  = 1'b0;
            lsb_valid = 1'b0;
        end
    endtask

    task automatic test_half_store();
        int t0, dc;
        logic wic;
        logic [31:0] d;
        @(posedge clk_in); #1;
        t0 = cyc;
        lsb_req(1'b1, 32'h1FFFE, 2'b01, 32'h0000_BEEF);
        push_ev(t0 + 1, 1'b1, 32'h1FFFE, 8'hEF);
        push_ev(t0 + 2, 1'b1, 32'h1FFFF, 8'hBE);
        wait_done(20, dc, wic, d);
        total++; if (dc !== t0 + 3 || wic !== 1'b0) begin
            bad++; $display("FAIL half_store_done got=%0d ic=%b exp=3 ic=0", dc - t0, wic);
        end
        @(posedge clk_in); #1;
        lsb_valid = 1'b0;
    endtask

    task automatic test_half_load();
        int t0, dc;
        logic wic;
        logic [31:0] d;
        @(posedge clk_in); #1;
        t0 = cyc;
        lsb_req(1'b0, 32'h410, 2'b01, 32'h0);
        push_ev(t0 + 1, 1'b0, 32'h410, 8'h00);
        push_ev(t0 + 2, 1'b0, 32'h411, 8'h00);
        wait_done(20, dc, wic, d);
        total++; if (dc !== t0 + 4) begin bad++; $display("FAIL half_load_latency got=%0d exp=4", dc - t0); end
        total++; if (d !== 32'h0000_ADDE) begin bad++; $display("FAIL half_load_data got=%h exp=0000adde", d); end
        @(posedge clk_in); #1;
        lsb_valid = 1'b0;
    endtask

    task automatic test_io_hold();
        int t0, dc;
        logic wic;
        logic [31:0] d;
        @(posedge clk_in); #1;
        t0 = cyc;
        io_buffer_full = 1'b1;
        lsb_req(1'b1, 32'h30000, 2'b00, 32'h0000_0041);
        for (int k = 1; k <= 5; k++) push_ev(t0 + k, 1'b0, 32'h30000, 8'h00);
        push_ev(t0 + 6, 1'b1, 32'h30000, 8'h41);
        repeat (6) @(posedge clk_in);
        #1;
        io_buffer_full = 1'b0;
        wait_done(20, dc, wic, d);
        total++; if (dc !== t0 + 7) begin bad++; $display("FAIL io_hold_done got=%0d exp=7", dc - t0); end
        @(posedge clk_in); #1;
        lsb_valid = 1'b0;
    endtask

    task automatic test_clr();
        int t0;
        int seen;
        @(posedge clk_in); #1;
        t0 = cyc;
        ic_valid = 1'b1;
        ic_addr  = 32'h100;
        push_ev(t0 + 1, 1'b0, 32'h100, 8'h00);
        push_ev(t0 + 2, 1'b0, 32'h101, 8'h00);
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        clr_in   = 1'b1;
        ic_valid = 1'b0;
        @(posedge clk_in); #1;
        clr_in = 1'b0;
        @(negedge clk_in);
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL clr_state got=%0d exp=%0d", dbg_state, IDLE); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            if (ic_done !== 1'b0) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL clr_no_done got=%0d pulses exp=0", seen); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL clr_bus_left got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_stall_load();
        int t0, dc;
        logic wic;
        logic [31:0] d;
        @(posedge clk_in); #1;
        t0 = cyc;
        lsb_req(1'b0, 32'h410, 2'b10, 32'h0);
        push_ev(t0 + 1, 1'b0, 32'h410, 8'h00);
        push_ev(t0 + 2, 1'b0, 32'h411, 8'h00);
        push_ev(t0 + 6, 1'b0, 32'h412, 8'h00);
        push_ev(t0 + 7, 1'b0, 32'h413, 8'h00);
        repeat (3) @(posedge clk_in);
        #1;
        rdy_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        rdy_in = 1'b1;
        wait_done(20, dc, wic, d);
        total++; if (dc !== t0 + 9) begin bad++; $display("FAIL stall_latency got=%0d exp=9", dc - t0); end
        total++; if (d !== 32'hEFBE_ADDE) begin bad++; $display("FAIL stall_data got=%h exp=efbeadde", d); end
        @(posedge clk_in); #1;
        lsb_valid = 1'b0;
    endtask

    task automatic test_wrap_size3();
        int t0, dc;
        logic wic;
        logic [31:0] d;
        @(posedge clk_in); #1;
        t0 = cyc;
        lsb_req(1'b1, 32'hFFFF_FFFE, 2'b11, 32'hA1B2_C3D4);
        push_ev(t0 + 1, 1'b1, 32'hFFFF_FFFE, 8'hD4);
        push_ev(t0 + 2, 1'b1, 32'hFFFF_FFFF, 8'hC3);
        push_ev(t0 + 3, 1'b1, 32'h0000_0000, 8'hB2);
        push_ev(t0 + 4, 1'b1, 32'h0000_0001, 8'hA1);
        wait_done(20, dc, wic, d);
        total++; if (dc !== t0 + 5) begin bad++; $display("FAIL wrap_done got=%0d exp=5", dc - t0); end
        @(posedge clk_in); #1;
        lsb_valid = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        int t0, dc, seen;
        logic wic;
        logic [31:0] d;
        @(posedge clk_in); #1;
        t0 = cyc;
        lsb_req(1'b1, 32'h500, 2'b10, 32'h1122_3344);
        push_ev(t0 + 1, 1'b1, 32'h500, 8'h44);
        push_ev(t0 + 2, 1'b1, 32'h501, 8'h33);
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        @(negedge clk_in);
        #1;
        rst_in = 1'b0;
        #1;
        total++; if (mem_a !== '0)       begin bad++; $display("FAIL rstmid_mem_a got=%h exp=0", mem_a); end
        total++; if (mem_wr !== 1'b0)    begin bad++; $display("FAIL rstmid_mem_wr got=%b exp=0", mem_wr); end
        total++; if (mem_dout !== 8'h00) begin bad++; $display("FAIL rstmid_mem_dout got=%h exp=0", mem_dout); end
        lsb_valid = 1'b0;
        lsb_wr    = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            if (lsb_done !== 1'b0 || ic_done !== 1'b0) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d pulses exp=0", seen); end
        @(posedge clk_in); #1;
        t0 = cyc;
        ic_valid = 1'b1;
        ic_addr  = 32'h100;
        for (int k = 0; k < 4; k++) push_ev(t0 + 1 + k, 1'b0, 32'h100 + 32'(k), 8'h00);
        wait_done(20, dc, wic, d);
        total++; if (dc !== t0 + 6 || d !== 32'h0010_0513) begin
            bad++; $display("FAIL rstmid_refetch got lat=%0d data=%h exp lat=6 data=00100513", dc - t0, d);
        end
        @(posedge clk_in); #1;
        ic_valid = 1'b0;
    endtask

    initial begin
        rst_in         = 1'b0;
        rdy_in         = 1'b1;
        clr_in         = 1'b0;
        io_buffer_full = 1'b0;
        ic_valid       = 1'b0;
        ic_addr        = '0;
        lsb_valid      = 1'b0;
        lsb_wr         = 1'b0;
        lsb_addr       = '0;
        lsb_size       = 2'b00;
        lsb_wdata      = 32'h0;

        test_reset();
        test_icache_fetch();
        test_round_robin();
        test_half_store();
        test_half_load();
        test_io_hold();
        test_clr();
        test_stall_load();
        test_wrap_size3();
        test_reset_mid_write();

        repeat (4) @(posedge clk_in);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL final_bus_left got=%0d exp=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
